// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 device-to-host receiver.
// Synchronizes and de-glitches the raw PS/2 clock and data lines, assembles
// 11-bit frames (start, 8 data LSB first, odd parity, stop), and folds the
// E0 / F0 / E1 prefixes into single key events for the keyboard matrix.
//
// Optional build macro: PS2_WATCHDOG_EN
//   Defined   - a mid-frame watchdog aborts a frame that stalls for
//               TIMEOUT_CYCLES clk_sys cycles without a filtered falling edge.
//   Undefined - no watchdog; a truncated frame waits for further falls.
//
// Frame FSM states:
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | waiting for a start bit (data low on a filtered fall)
//   ST_DATA   | shifting in the 8 data bits, LSB first
//   ST_PARITY | capturing the odd-parity bit
//   ST_STOP   | checking the stop bit and parity, handing the byte on

module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2400000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_strobe,
  output logic       key_pressed,
  output logic       key_extended,
  output logic [7:0] key_code,
  output logic       rx_error
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // Terminal count of the filter: the FILTER_LEN-th consecutive differing sample.
  localparam logic [7:0] FILT_TC = 8'(FILTER_LEN - 1);

  logic       clk_meta;
  logic       clk_sync;
  logic       data_meta;
  logic       data_sync;

  logic [7:0] filt_cnt;
  logic       fclk;
  logic       fall;

  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       parity_bit;

  logic       frame_end;
  logic       frame_ok;
  logic       wd_timeout;
  logic       is_filler;

  logic       ext;
  logic       brk;
  logic [2:0] skip_cnt;

  // Two-flop synchronizers for both asynchronous PS/2 pins; lines idle high.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  // Glitch filter: fclk follows clk_sync only after FILTER_LEN agreeing samples.
  // fall is a single-cycle pulse in the first cycle fclk reads low.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      filt_cnt <= 8'd0;
      fclk     <= 1'b1;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync != fclk) begin
        if (filt_cnt == FILT_TC) begin
          fclk     <= clk_sync;
          filt_cnt <= 8'd0;
          fall     <= ~clk_sync;
        end else begin
          filt_cnt <= filt_cnt + 8'd1;
        end
      end else begin
        filt_cnt <= 8'd0;
      end
    end
  end

`ifdef PS2_WATCHDOG_EN
  localparam logic [21:0] WD_LOAD = 22'(TIMEOUT_CYCLES - 1);

  logic [21:0] wd_cnt;

  // Watchdog down-counter: reloaded while idle and on every fall, so reaching
  // zero means TIMEOUT_CYCLES cycles have passed since the last fall mid-frame.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wd_cnt <= WD_LOAD;
    end else if ((state == ST_IDLE) || fall) begin
      wd_cnt <= WD_LOAD;
    end else if (wd_cnt != 22'd0) begin
      wd_cnt <= wd_cnt - 22'd1;
    end
  end

  assign wd_timeout = (state != ST_IDLE) && !fall && (wd_cnt == 22'd0);
`else
  logic unused_wd_param;

  assign wd_timeout      = 1'b0;
  assign unused_wd_param = ^TIMEOUT_CYCLES;
`endif

  // Frame FSM: advances only on a filtered falling edge of the PS/2 clock.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'd0;
      parity_bit <= 1'b0;
    end else if (wd_timeout) begin
      state   <= ST_IDLE;
      bit_cnt <= 3'd0;
    end else if (fall) begin
      case (state)
        ST_IDLE: begin
          if (!data_sync) begin
            state   <= ST_DATA;
            bit_cnt <= 3'd0;
          end
        end
        ST_DATA: begin
          shift_reg <= {data_sync, shift_reg[7:1]};
          if (bit_cnt == 3'd7) begin
            state <= ST_PARITY;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        ST_PARITY: begin
          parity_bit <= data_sync;
          state      <= ST_STOP;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // The stop-bit fall completes a frame; valid needs stop=1 and odd parity.
  assign frame_end = fall && (state == ST_STOP);
  assign frame_ok  = data_sync && (^{shift_reg, parity_bit});

  // Controller acknowledgements and fillers that never map to a key.
  always_comb begin
    is_filler = 1'b0;
    case (shift_reg)
      8'h00, 8'hAA, 8'hEE, 8'hFA,
      8'hFC, 8'hFD, 8'hFE, 8'hFF: is_filler = 1'b1;
      default:                    is_filler = 1'b0;
    endcase
  end

  // Prefix folding and key event output; outputs hold until the next strobe.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      key_strobe   <= 1'b0;
      key_pressed  <= 1'b0;
      key_extended <= 1'b0;
      key_code     <= 8'h00;
      rx_error     <= 1'b0;
      ext          <= 1'b0;
      brk          <= 1'b0;
      skip_cnt     <= 3'd0;
    end else begin
      key_strobe <= 1'b0;
      rx_error   <= 1'b0;
      if (wd_timeout) begin
        rx_error <= 1'b1;
        ext      <= 1'b0;
        brk      <= 1'b0;
        skip_cnt <= 3'd0;
      end else if (frame_end) begin
        if (!frame_ok) begin
          rx_error <= 1'b1;
          ext      <= 1'b0;
          brk      <= 1'b0;
          skip_cnt <= 3'd0;
        end else if (skip_cnt != 3'd0) begin
          skip_cnt <= skip_cnt - 3'd1;
        end else if (shift_reg == 8'hE1) begin
          // Pause/Break: the remaining 7 bytes of the sequence are swallowed.
          skip_cnt <= 3'd7;
          ext      <= 1'b0;
          brk      <= 1'b0;
        end else if (shift_reg == 8'hE0) begin
          ext <= 1'b1;
        end else if (shift_reg == 8'hF0) begin
          brk <= 1'b1;
        end else if (is_filler) begin
          ext <= 1'b0;
          brk <= 1'b0;
        end else begin
          key_strobe   <= 1'b1;
          key_code     <= shift_reg;
          key_pressed  <= ~brk;
          key_extended <= ext;
          ext          <= 1'b0;
          brk          <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: scoreboard bench for the PS/2 receiver.
// Expected key events are queued as frames are driven and popped when
// key_strobe fires. Watchdog scenario runs only with PS2_WATCHDOG_EN.

module tb_ps2_scancode_rx;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic       key_strobe;
  logic       key_pressed;
  logic       key_extended;
  logic [7:0] key_code;
  logic       rx_error;

  typedef struct {
    logic [7:0] code;
    logic       pressed;
    logic       ext;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;

  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          strobe_cnt = 0;
  int          err_cnt = 0;
  int          exp_err = 0;
  int unsigned last_strobe_cyc = 0;
  int unsigned last_err_cyc = 0;
  int unsigned last_fall_drive_cyc = 0;

  ps2_scancode_rx #(
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .key_strobe  (key_strobe),
    .key_pressed (key_pressed),
    .key_extended(key_extended),
    .key_code    (key_code),
    .rx_error    (rx_error)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk_sys) begin
    if (key_strobe === 1'b1) begin
      strobe_cnt++;
      last_strobe_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("strobe_expected", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("key_code", {24'h0, key_code}, {24'h0, mon_e.code});
        chk("key_pressed", {31'h0, key_pressed}, {31'h0, mon_e.pressed});
        chk("key_extended", {31'h0, key_extended}, {31'h0, mon_e.ext});
      end
    end
    if (rx_error === 1'b1) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic push_ev(input logic [7:0] code, input logic pressed, input logic ext);
    ev_t e;
    e.code    = code;
    e.pressed = pressed;
    e.ext     = ext;
    exp_q.push_back(e);
  endtask

  // One PS/2 bit cell; glitch adds a 5-cycle pulse inside each clock phase.
  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    wait_cyc(10);
    ps2_clk = 1'b0;
    last_fall_drive_cyc = cyc;
    if (glitch) begin
      wait_cyc(12);
      ps2_clk = 1'b1;
      wait_cyc(5);
      ps2_clk = 1'b0;
      wait_cyc(8);
    end else begin
      wait_cyc(25);
    end
    ps2_clk = 1'b1;
    if (glitch) begin
      wait_cyc(12);
      ps2_clk = 1'b0;
      wait_cyc(5);
      ps2_clk = 1'b1;
      wait_cyc(3);
    end else begin
      wait_cyc(20);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit glitch);
    logic [10:0] bits;
    logic        par;
    par  = (~^b) ^ bad_par;
    bits = {~bad_stop, par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i], glitch);
    ps2_data = 1'b1;
    wait_cyc(30);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #900_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    chk("rst_strobe", {31'h0, key_strobe}, 0);
    chk("rst_pressed", {31'h0, key_pressed}, 0);
    chk("rst_ext", {31'h0, key_extended}, 0);
    chk("rst_code", {24'h0, key_code}, 0);
    chk("rst_error", {31'h0, rx_error}, 0);
    reset = 1'b0;
    wait_cyc(20);

    // Single make code and its latency from the stop-bit clock drive.
    push_ev(8'h1C, 1'b1, 1'b0);
    send_byte(8'h1C);
    chk("latency", last_strobe_cyc - last_fall_drive_cyc, 11);
    chk("strobes_1", strobe_cnt, 1);
    chk("errors_1", err_cnt, exp_err);

    // Break, extended make, extended break.
    push_ev(8'h1C, 1'b0, 1'b0);
    push_ev(8'h75, 1'b1, 1'b1);
    push_ev(8'h75, 1'b0, 1'b1);
    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    chk("strobes_2", strobe_cnt, 4);
    wait_cyc(100);
    chk("hold_code", {24'h0, key_code}, 32'h75);
    chk("hold_pressed", {31'h0, key_pressed}, 0);
    chk("hold_ext", {31'h0, key_extended}, 1);
    chk("hold_strobe_low", {31'h0, key_strobe}, 0);

    // Parity error clears a pending break; stop error clears a pending E0.
    push_ev(8'h29, 1'b1, 1'b0);
    send_byte(8'hF0);
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    exp_err++;
    chk("errors_parity", err_cnt, exp_err);
    send_byte(8'h29);
    push_ev(8'h5A, 1'b1, 1'b0);
    send_byte(8'hE0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    exp_err++;
    chk("errors_stop", err_cnt, exp_err);
    send_byte(8'h5A);
    chk("strobes_3", strobe_cnt, 6);

    // Idle glitch with data low must not start a frame; then a glitched frame.
    ps2_data = 1'b0;
    wait_cyc(10);
    ps2_clk = 1'b0;
    wait_cyc(5);
    ps2_clk = 1'b1;
    wait_cyc(30);
    ps2_data = 1'b1;
    wait_cyc(20);
    push_ev(8'h4D, 1'b1, 1'b0);
    send_frame(8'h4D, 1'b0, 1'b0, 1'b1);
    chk("errors_glitch", err_cnt, exp_err);
    chk("strobes_4", strobe_cnt, 7);

    // Filler bytes are dropped and clear pending prefixes.
    push_ev(8'h1C, 1'b1, 1'b0);
    push_ev(8'h1B, 1'b1, 1'b0);
    send_byte(8'hE0); send_byte(8'hAA); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'hFA); send_byte(8'h1B);
    send_byte(8'h00); send_byte(8'hFF);
    chk("strobes_5", strobe_cnt, 9);

    // Pause sequence swallowed whole.
    push_ev(8'h76, 1'b1, 1'b0);
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    chk("strobes_pause", strobe_cnt, 9);
    send_byte(8'h76);
    chk("strobes_6", strobe_cnt, 10);

    // Reset in the middle of a frame: outputs cleared, no error, next frame ok.
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    reset = 1'b1;
    wait_cyc(3);
    chk("mrst_code", {24'h0, key_code}, 0);
    chk("mrst_strobe", {31'h0, key_strobe}, 0);
    chk("mrst_error", {31'h0, rx_error}, 0);
    reset = 1'b0;
    wait_cyc(20);
    chk("errors_mrst", err_cnt, exp_err);
    push_ev(8'h3A, 1'b1, 1'b0);
    send_byte(8'h3A);
    chk("strobes_7", strobe_cnt, 11);

`ifdef PS2_WATCHDOG_EN
    // Truncated frame aborted by the watchdog, then a clean frame.
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    ps2_data = 1'b1;
    wait_cyc(1100);
    exp_err++;
    chk("errors_wd", err_cnt, exp_err);
    chk("wd_latency", last_err_cyc - last_fall_drive_cyc, 1011);
    push_ev(8'h5A, 1'b1, 1'b0);
    send_byte(8'h5A);
    chk("strobes_wd", strobe_cnt, 12);
`endif

    wait_cyc(50);
    chk("queue_empty", exp_q.size(), 0);
    chk("errors_final", err_cnt, exp_err);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
- PS/2 device-to-host receiver. Samples the raw keyboard clock and data lines and assembles 11-bit frames.
- Folds E0/F0 prefixes into per-key events and emits them on the key_strobe/key_pressed/key_extended/key_code interface consumed by the keyboard matrix block.
- Sits between the board PS/2 pins (or the IO controller's PS/2 pass-through) and the keyboard matrix. Receive only; no host-to-device transmission.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronized samples required before the filtered PS/2 clock changes state (range 2..255).
- TIMEOUT_CYCLES, 2400000: clk_sys cycles without a filtered falling edge mid-frame before abort. Only used with the watchdog macro.

Ports:
- clk_sys  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous, idle high
- ps2_data  input  1  raw PS/2 data pin, asynchronous
- key_strobe  output  1  one-cycle pulse: new key event valid
- key_pressed  output  1  1 = make, 0 = break
- key_extended  output  1  1 = event was E0-prefixed
- key_code  output  8  scan code byte with prefixes stripped
- rx_error  output  1  one-cycle pulse on a discarded frame (parity, stop, timeout)

Behaviour:
- Sync: ps2_clk and ps2_data each pass through two flops.
- Filter:
  - Counter tracks the synchronized clock.
  - Filtered clock (fclk) flips only after FILTER_LEN consecutive samples differ from the current fclk.
  - fall = fclk 1->0 transition. Data is sampled (synchronized) in the same cycle as fall.
- Frame FSM states: IDLE, DATA, PARITY, STOP. Transitions occur only on fall.
  - IDLE: data=0 -> DATA with bit counter 0. data=1 -> stay IDLE, no error.
  - DATA: shift in LSB first. After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: frame valid iff data=1 and the 9 bits (data+parity) have odd weight. Always returns to IDLE.
- Invalid frame:
  - rx_error pulses 1 cycle after the stop-bit fall.
  - Byte discarded; ext, brk and skip count cleared.
- Valid byte B, processed the cycle after the stop-bit fall:
  - skip count > 0: decrement, no strobe.
  - B=E1: skip count = 7 (pause sequence swallowed), ext/brk cleared, no strobe.
  - B=E0: ext=1, no strobe.
  - B=F0: brk=1, no strobe.
  - B in {00, AA, EE, FA, FC, FD, FE, FF}: dropped, ext/brk cleared, no strobe.
  - Otherwise: key_strobe=1 for exactly one cycle, with key_code=B, key_pressed=~brk, key_extended=ext. ext and brk are then cleared.
- Latency: key_strobe asserts 1 clk_sys cycle after the stop-bit fall.
- Output hold: key_code, key_pressed and key_extended are registered together with key_strobe and hold until the next strobe.
- Back-to-back frames: the next start-bit fall may arrive in the cycle after STOP; it is accepted.
- Reset, including mid-frame:
  - FSM to IDLE; shift register, bit counter and filter counters cleared.
  - fclk=1; ext/brk/skip cleared.
  - key_strobe=0, key_pressed=0, key_extended=0, key_code=00, rx_error=0.
  - A partially received frame is lost with no rx_error pulse.
- Idle-state clock-high timeouts and inter-byte gaps are not checked.

Optional Feature:
- Macro PS2_WATCHDOG_EN.
- Defined:
  - A 22-bit counter runs while the FSM is not IDLE and clears on every fall.
  - Reaching TIMEOUT_CYCLES forces IDLE, pulses rx_error for 1 cycle, and clears ext/brk/skip.
- Undefined: no counter. A truncated frame stays pending until further falls complete it (misaligned data is caught only by the parity/stop checks).

Test Plan:
- Frame 1C (parity 0, stop 1), FILTER_LEN=8 -> one key_strobe 1 cycle after the stop fall, with key_code=1C, key_pressed=1, key_extended=0, rx_error=0.
- Frames F0,1C then E0,75 then E0,F0,75 -> exactly three strobes:
  - (1C, pressed 0, ext 0)
  - (75, pressed 1, ext 1)
  - (75, pressed 0, ext 1)
- Frame 1C with parity bit 1 -> rx_error pulse, no strobe. Following frame 29 -> strobe with code 29, pressed 1.
- 5-cycle low glitch on ps2_clk while idle, and 5-cycle glitches inside a frame -> no state change, no strobe. The frame still decodes correctly.
- Pause sequence E1,14,77,E1,F0,14,F0,77, then frame 76 -> no strobes during the sequence; one strobe with code 76.
- Watchdog build, TIMEOUT_CYCLES=1000: start bit plus 4 data bits, then ps2_clk held high -> rx_error at 1000 cycles after the last fall, FSM IDLE. Next full frame 5A -> strobe with code 5A. Also, reset asserted mid-frame -> all outputs 0 and the next frame decodes.
